// File: rtl/fc_pkg.sv
// Shared types for the fc output path: collector FSM states and frame counter width.
package fc_pkg;
  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} coll_state_t;
  localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/fc_argmax_track.sv
// Running argmax over one frame; the first word loads unconditionally, later words win only if strictly greater.
module fc_argmax_track #(
  parameter int M = 6,
  parameter int T = 8,
  localparam int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                first,
  input  logic                en,
  input  logic [IW-1:0]       idx,
  input  logic signed [T-1:0] data,
  output logic [IW-1:0]       max_idx,
  output logic signed [T-1:0] max_val
);
  always_ff @(posedge clk) begin
    if (clear) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (en && (first || data > max_val)) begin
      // strict compare keeps the lower index on ties
      max_idx <= idx;
      max_val <= data;
    end
  end
endmodule

// File: rtl/fc_output_collector.sv
// Collects M signed words from an fc layer stream into one vector with argmax and hands it off downstream.
module fc_output_collector
  import fc_pkg::*;
#(
  parameter int M = 6,
  parameter int T = 8,
  localparam int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [T-1:0]    in_data,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic [M*T-1:0]         vec_data,
  output logic [IW-1:0]          max_idx,
  output logic signed [T-1:0]    max_val,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  coll_state_t           state;
  logic [IW-1:0]         cnt;
  logic [M-1:0][T-1:0]   words_q;
  logic                  accept;
  logic                  last;

  assign in_ready  = (state == COLLECT);
  assign vec_valid = (state == PRESENT);
  assign accept    = in_valid && (state == COLLECT);
  assign last      = (cnt == IW'(M - 1));
  assign vec_data  = words_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= COLLECT;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        COLLECT: if (in_valid) begin
          if (last) begin
            cnt   <= '0;
            state <= PRESENT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESENT: if (vec_ready) begin
          state     <= COLLECT;
          frame_cnt <= frame_cnt + 1'b1;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // one slot register per word; only the slot addressed by cnt captures
  for (genvar i = 0; i < M; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!reset)
        words_q[i] <= '0;
      else if (accept && cnt == IW'(i))
        words_q[i] <= in_data;
    end
  end

  fc_argmax_track #(.M(M), .T(T)) u_argmax (
    .clk     (clk),
    .clear   (!reset),
    .first   (cnt == '0),
    .en      (accept),
    .idx     (cnt),
    .data    (in_data),
    .max_idx (max_idx),
    .max_val (max_val)
  );
endmodule

// File: tb/tb_fc_output_collector.sv
// Randomized self-checking bench for fc_output_collector against a frame-level argmax model.
module tb_fc_output_collector;
  localparam int M = 6;
  localparam int T = 8;

  typedef logic signed [T-1:0] word_t;
  typedef word_t frame_t [M];

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  word_t         in_data;
  logic          vec_valid;
  logic          vec_ready;
  logic [M*T-1:0] vec_data;
  logic [2:0]    max_idx;
  word_t         max_val;
  logic [15:0]   frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  fc_output_collector #(.M(M), .T(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .max_idx   (max_idx),
    .max_val   (max_val),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_max(input frame_t w, output int idx, output int val);
    idx = 0;
    val = int'(w[0]);
    for (int i = 1; i < M; i++)
      if (int'(w[i]) > val) begin
        val = int'(w[i]);
        idx = i;
      end
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < M; i++) f[i] = word_t'($urandom_range(255));
    return f;
  endfunction

  // stimulus only: pushes M words, optionally with random idle gaps and random vec_ready noise
  task automatic feed(input frame_t w, input bit gaps);
    for (int i = 0; i < M; i++) begin
      if (gaps)
        while ($urandom_range(1) == 1) begin
          in_valid  = 1'b0;
          in_data   = word_t'($urandom_range(255));
          vec_ready = 1'($urandom_range(1));
          step();
        end
      in_valid  = 1'b1;
      in_data   = w[i];
      vec_ready = gaps ? 1'($urandom_range(1)) : 1'b0;
      step();
    end
    in_valid  = 1'b0;
    vec_ready = 1'b0;
  endtask

  task automatic deliver();
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; vec_ready = 1'b0;
    do_reset();
    n_checks++;
    if (in_ready !== 1'b1 || vec_valid !== 1'b0 || vec_data !== '0 || max_idx !== 3'd0 ||
        max_val !== 8'sd0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vv=%b data=%h idx=%0d val=%0d cnt=%0d, required 1 0 0 0 0 0",
               in_ready, vec_valid, vec_data, max_idx, max_val, frame_cnt);
    end
  endtask

  task automatic test_directed();
    frame_t w = '{8'sd3, -8'sd1, 8'sd7, 8'sd0, 8'sd7, -8'sd8};
    for (int i = 0; i < M; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      step();
      n_checks++;
      if (vec_valid !== (i == M - 1)) begin
        n_fail++;
        $display("FAIL latency word %0d: vec_valid=%b required %b", i, vec_valid, i == M - 1);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < M; i++) begin
      n_checks++;
      if (vec_data[i*T +: T] !== w[i]) begin
        n_fail++;
        $display("FAIL directed word %0d: got %0d required %0d", i, $signed(vec_data[i*T +: T]), w[i]);
      end
    end
    n_checks++;
    if (max_idx !== 3'd2 || max_val !== 8'sd7) begin
      n_fail++;
      $display("FAIL directed argmax: got idx=%0d val=%0d required idx=2 val=7", max_idx, max_val);
    end
    deliver();
    n_checks++;
    if (frame_cnt !== 16'(exp_cnt) || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL directed deliver: cnt=%0d rdy=%b required cnt=%0d rdy=1", frame_cnt, in_ready, exp_cnt);
    end
  endtask

  task automatic test_all_equal();
    word_t vals [2] = '{-8'sd5, -8'sd128};
    frame_t w;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < M; i++) w[i] = vals[k];
      feed(w, 1'b0);
      n_checks++;
      if (vec_valid !== 1'b1 || max_idx !== 3'd0 || max_val !== vals[k]) begin
        n_fail++;
        $display("FAIL all_equal %0d: vv=%b idx=%0d val=%0d required vv=1 idx=0 val=%0d",
                 k, vec_valid, max_idx, max_val, vals[k]);
      end
      deliver();
    end
  endtask

  task automatic test_backpressure();
    frame_t w = rand_frame();
    frame_t w2 = rand_frame();
    logic [M*T-1:0] held;
    logic [2:0] hidx;
    word_t hval;
    int eidx, eval;
    do_reset();
    feed(w, 1'b0);
    held = vec_data; hidx = max_idx; hval = max_val;
    in_valid  = 1'b1;
    vec_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_data = word_t'($urandom_range(255));
      step();
      n_checks++;
      if (in_ready !== 1'b0 || vec_valid !== 1'b1 || vec_data !== held || max_idx !== hidx || max_val !== hval) begin
        n_fail++;
        $display("FAIL hold cycle %0d: rdy=%b vv=%b data=%h idx=%0d val=%0d", c, in_ready, vec_valid, vec_data, max_idx, max_val);
      end
    end
    in_valid = 1'b0;
    deliver();
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL backpressure frame_cnt: got %0d required 1", frame_cnt);
    end
    feed(w2, 1'b0);
    model_max(w2, eidx, eval);
    n_checks++;
    if (vec_valid !== 1'b1 || vec_data[T-1:0] !== w2[0] || max_idx !== 3'(eidx) || max_val !== word_t'(eval)) begin
      n_fail++;
      $display("FAIL next_frame: vv=%b w0=%0d idx=%0d val=%0d required 1 %0d %0d %0d",
               vec_valid, $signed(vec_data[T-1:0]), max_idx, max_val, w2[0], eidx, eval);
    end
    deliver();
  endtask

  task automatic test_random();
    frame_t w;
    int eidx, eval, bad;
    do_reset();
    for (int f = 0; f < 100; f++) begin
      w = rand_frame();
      // bias some frames toward ties and extreme values
      if (f % 7 == 0) w[$urandom_range(M-1)] = w[$urandom_range(M-1)];
      if (f % 11 == 0) w[$urandom_range(M-1)] = -8'sd128;
      feed(w, 1'b1);
      model_max(w, eidx, eval);
      bad = 0;
      for (int i = 0; i < M; i++) if (vec_data[i*T +: T] !== w[i]) bad++;
      n_checks++;
      if (vec_valid !== 1'b1 || bad != 0 || max_idx !== 3'(eidx) || max_val !== word_t'(eval)) begin
        n_fail++;
        $display("FAIL random frame %0d: vv=%b bad_words=%0d idx=%0d val=%0d required idx=%0d val=%0d",
                 f, vec_valid, bad, max_idx, max_val, eidx, eval);
      end
      deliver();
    end
    n_checks++;
    if (frame_cnt !== 16'd100) begin
      n_fail++;
      $display("FAIL random frame_cnt: got %0d required 100", frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    frame_t p = rand_frame();
    frame_t w = rand_frame();
    int eidx, eval, bad;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = p[i]; step();
    end
    in_valid = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (vec_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midframe idle %0d: vv=%b rdy=%b required 0 1", c, vec_valid, in_ready);
      end
    end
    feed(w, 1'b0);
    model_max(w, eidx, eval);
    bad = 0;
    for (int i = 0; i < M; i++) if (vec_data[i*T +: T] !== w[i]) bad++;
    n_checks++;
    if (vec_valid !== 1'b1 || bad != 0 || max_idx !== 3'(eidx) || max_val !== word_t'(eval) || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midframe recovery: vv=%b bad_words=%0d idx=%0d val=%0d cnt=%0d required idx=%0d val=%0d cnt=0",
               vec_valid, bad, max_idx, max_val, frame_cnt, eidx, eval);
    end
    deliver();
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_directed();
    test_all_equal();
    test_backpressure();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
